// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives all 16 {A,B,C,D} vectors into a 4-input block,
// captures f per vector and scores the result against an expected mask.
module truth_table_sweeper #(
  parameter int unsigned HOLD     = 2,
  parameter logic [15:0] EXPECTED = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        f,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic [4:0]  mismatch_cnt,
  output logic        pass
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_DONE
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

  state_t     state;
  logic [3:0] idx;
  logic [7:0] hcnt;

  logic       last;
  logic       miss;
  logic [4:0] cnt_next;

  always_comb begin
    last     = (hcnt == HOLD_LAST);
    miss     = f ^ EXPECTED[idx];
    cnt_next = mismatch_cnt + {4'd0, miss};
  end

  // pass is taken from cnt_next so the idx 15 compare is included
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      idx          <= 4'd0;
      hcnt         <= 8'd0;
      {A, B, C, D} <= 4'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      truth_table  <= 16'd0;
      mismatch_cnt <= 5'd0;
      pass         <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state        <= S_DRIVE;
            idx          <= 4'd0;
            hcnt         <= 8'd0;
            {A, B, C, D} <= 4'd0;
            busy         <= 1'b1;
            truth_table  <= 16'd0;
            mismatch_cnt <= 5'd0;
            pass         <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (!last) begin
            hcnt <= hcnt + 8'd1;
          end else begin
            hcnt              <= 8'd0;
            truth_table[idx]  <= f;
            mismatch_cnt      <= cnt_next;
            if (idx == 4'd15) begin
              state        <= S_DONE;
              {A, B, C, D} <= 4'd0;
              busy         <= 1'b0;
              done         <= 1'b1;
              pass         <= (cnt_next == 5'd0);
            end else begin
              idx          <= idx + 4'd1;
              {A, B, C, D} <= idx + 4'd1;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: HOLD=2 instance for AND/const/
// abort/back-to-back sweeps, HOLD=1 instance for the parity sweep.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start2 = 1'b0;
  logic start1 = 1'b0;
  int   fmode = 0;

  logic        a2, b2, c2, d2, busy2, done2, pass2, f2;
  logic [15:0] tt2;
  logic [4:0]  cnt2;
  logic        a1, b1, c1, d1, busy1, done1, pass1, f1;
  logic [15:0] tt1;
  logic [4:0]  cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // function blocks under test: 0 = AND, 1 = const 0, 2 = const 1
  always_comb begin
    f2 = a2 & b2 & c2 & d2;
    if (fmode == 1) f2 = 1'b0;
    if (fmode == 2) f2 = 1'b1;
    f1 = a1 ^ b1 ^ c1 ^ d1;
  end

  truth_table_sweeper #(.HOLD(2), .EXPECTED(16'h8000)) u2 (
    .clk(clk), .rst(rst), .start(start2), .f(f2),
    .A(a2), .B(b2), .C(c2), .D(d2),
    .busy(busy2), .done(done2), .truth_table(tt2),
    .mismatch_cnt(cnt2), .pass(pass2)
  );

  truth_table_sweeper #(.HOLD(1), .EXPECTED(16'h6996)) u1 (
    .clk(clk), .rst(rst), .start(start1), .f(f1),
    .A(a1), .B(b1), .C(c1), .D(d1),
    .busy(busy1), .done(done1), .truth_table(tt1),
    .mismatch_cnt(cnt1), .pass(pass1)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Pulses start, then samples every negedge up to
  // the first IDLE cycle after done (k = 16*H+1 edges after accept).
  task automatic sweep(input bit sel, input bit extra,
                       output int lat, output int nbusy,
                       output int ndone, output int verr,
                       output int clr);
    int h;
    int k;
    logic [3:0] v;
    h = sel ? 1 : 2;
    lat = -1; nbusy = 0; ndone = 0; verr = 0; clr = 0;
    if (sel) start1 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    if (sel) start1 = 1'b0; else start2 = 1'b0;
    for (k = 0; k <= 16 * h + 1; k++) begin
      if (sel) begin
        v = {a1, b1, c1, d1};
        if (busy1) nbusy++;
        if (done1) begin ndone++; if (lat < 0) lat = k; end
        if (k == 0 && (tt1 != 0 || cnt1 != 0 || pass1)) clr = 1;
      end else begin
        v = {a2, b2, c2, d2};
        if (busy2) nbusy++;
        if (done2) begin ndone++; if (lat < 0) lat = k; end
        if (k == 0 && (tt2 != 0 || cnt2 != 0 || pass2)) clr = 1;
      end
      if (k < 16 * h && int'(v) != k / h) verr++;
      if (k >= 16 * h && v != 4'd0) verr++;
      if (extra && !sel)
        start2 = (k == 6 || k == 30 || done2);
      if (k < 16 * h + 1) @(negedge clk);
    end
    start2 = 1'b0;
  endtask

  task automatic check_sweep2(input string tag, input int lat, input int nb,
                              input int nd, input int ve, input int cl);
    check({tag, "_latency"}, lat, 32);
    check({tag, "_busy_cycles"}, nb, 32);
    check({tag, "_done_pulses"}, nd, 1);
    check({tag, "_vector_seq"}, ve, 0);
    check({tag, "_clear_at_accept"}, cl, 0);
  endtask

  initial begin
    int lat, nb, nd, ve, cl, n;

    // reset state
    @(negedge clk);
    check("reset_u2_outputs",
          {a2, b2, c2, d2, busy2, done2, tt2, cnt2, pass2}, 0);
    check("reset_u1_outputs",
          {a1, b1, c1, d1, busy1, done1, tt1, cnt1, pass1}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // baseline AND
    fmode = 0;
    sweep(1'b0, 1'b0, lat, nb, nd, ve, cl);
    check_sweep2("and", lat, nb, nd, ve, cl);
    check("and_table", tt2, 16'h8000);
    check("and_cnt", cnt2, 0);
    check("and_pass", pass2, 1);

    // f tied 0, then tied 1
    fmode = 1;
    sweep(1'b0, 1'b0, lat, nb, nd, ve, cl);
    check("zero_latency", lat, 32);
    check("zero_table", tt2, 16'h0000);
    check("zero_cnt", cnt2, 1);
    check("zero_pass", pass2, 0);
    fmode = 2;
    sweep(1'b0, 1'b0, lat, nb, nd, ve, cl);
    check("one_table", tt2, 16'hFFFF);
    check("one_cnt", cnt2, 15);
    check("one_pass", pass2, 0);

    // back-to-back: restart in the first IDLE cycle after done
    fmode = 0;
    sweep(1'b0, 1'b0, lat, nb, nd, ve, cl);
    check_sweep2("b2b", lat, nb, nd, ve, cl);
    check("b2b_table", tt2, 16'h8000);
    check("b2b_cnt", cnt2, 0);
    check("b2b_pass", pass2, 1);

    // parity with HOLD = 1
    sweep(1'b1, 1'b0, lat, nb, nd, ve, cl);
    check("par_latency", lat, 16);
    check("par_busy_cycles", nb, 16);
    check("par_done_pulses", nd, 1);
    check("par_vector_seq", ve, 0);
    check("par_table", tt1, 16'h6996);
    check("par_cnt", cnt1, 0);
    check("par_pass", pass1, 1);
    check("par_u2_untouched", tt2, 16'h8000);

    // start pulses while busy and during done
    fmode = 1;
    sweep(1'b0, 1'b0, lat, nb, nd, ve, cl);
    fmode = 0;
    @(negedge clk);
    sweep(1'b0, 1'b1, lat, nb, nd, ve, cl);
    check_sweep2("busy_start", lat, nb, nd, ve, cl);
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy2 || done2) n++;
    end
    check("busy_start_no_restart", n, 0);
    check("busy_start_table", tt2, 16'h8000);
    check("busy_start_cnt", cnt2, 0);
    check("busy_start_pass", pass2, 1);

    // asynchronous reset while idx = 5
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_idx5", {a2, b2, c2, d2}, 5);
    #2 rst = 1'b1;
    #1;
    check("abort_outputs_zero",
          {a2, b2, c2, d2, busy2, done2, tt2, cnt2, pass2}, 0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (done2 || busy2) n++;
    end
    check("abort_no_done", n, 0);
    check("abort_pass_zero", pass2, 0);

    // fresh sweep after abort
    sweep(1'b0, 1'b0, lat, nb, nd, ve, cl);
    check_sweep2("fresh", lat, nb, nd, ve, cl);
    check("fresh_table", tt2, 16'h8000);
    check("fresh_cnt", cnt2, 0);
    check("fresh_pass", pass2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequential stimulus-and-capture stage that sits directly upstream of a 4-input combinational function block (inputs A, B, C, D; output f). On a start request it walks the 16 input vectors in ascending binary order and holds each for a programmable number of clock cycles. It samples the block's f output for every vector, assembles the 16-entry truth table, and compares it against an expected minterm mask. This replaces hand-written per-vector stimulus with a reusable, self-checking sweep.

## Interface
- HOLD, 2: clock cycles each vector is held before f is sampled; legal range 1..255; 0 is illegal.
- EXPECTED, 16'h0000: expected truth table; bit i is the required f for input index i.
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  sweep request; sampled only in IDLE.
- f  in  1  output of the downstream function block.
- A  out  1  function input, MSB of the vector index.
- B  out  1  function input.
- C  out  1  function input.
- D  out  1  function input, LSB of the vector index.
- busy  out  1  high while the sweep is in progress (DRIVE state).
- done  out  1  one-cycle pulse when the sweep completes.
- table  out  16  captured truth table; bit i = f sampled at index i.
- mismatch_cnt  out  5  number of indices where f differs from EXPECTED (0..16).
- pass  out  1  high when mismatch_cnt == 0; valid from done onward.

## Operation
- Vector index: idx = {A,B,C,D}, 4 bits, range 0..15.
- Hold counter: hcnt, 8 bits.
- States:
  - IDLE: A..D = 0, busy = 0, done = 0. table, mismatch_cnt and pass hold their last values. start = 1 moves to DRIVE.
  - DRIVE: busy = 1, {A,B,C,D} = idx.
    - While hcnt < HOLD-1: hcnt increments.
    - When hcnt == HOLD-1: table[idx] <= f; if f != EXPECTED[idx], mismatch_cnt increments. hcnt returns to 0.
    - If idx == 15, go to DONE; otherwise idx increments.
  - DONE: A..D = 0, busy = 0, done = 1 for exactly one cycle. Next state is IDLE unconditionally.
- pass is registered on the DRIVE→DONE edge from the final count, including the idx 15 compare.
- Accepting start in IDLE:
  - clears table, mismatch_cnt and pass to 0;
  - sets idx = 0 and hcnt = 0.
- start is ignored in DRIVE and DONE; requests are not queued.
- idx never wraps. The sweep terminates after idx 15.

## Timing
- Reset (asynchronous, any state): state = IDLE, idx = 0, hcnt = 0, and every output is 0 (A, B, C, D, busy, done, table, mismatch_cnt, pass).
- Reset mid-sweep aborts the sweep: no done pulse and no partial pass.
- Let T0 be the clock edge at which start = 1 is accepted:
  - Vector i drives A..D from edge T0 + i·HOLD until edge T0 + (i+1)·HOLD.
  - f for vector i is sampled at edge T0 + (i+1)·HOLD. The downstream block therefore gets HOLD cycles to settle.
  - The last sample is at edge T0 + 16·HOLD; the state becomes DONE and done is high for the following cycle.
  - The state is back in IDLE at edge T0 + 16·HOLD + 1. Total latency from start to done is 16·HOLD cycles.
- HOLD = 1 gives one vector per cycle, with hcnt permanently 0.
- table, mismatch_cnt and pass are stable from the done cycle until the next accepted start or reset.

## Test plan
- Baseline AND: f = A&B&C&D, EXPECTED = 16'h8000, HOLD = 2, start pulsed at T0.
  - done at exactly cycle T0 + 32.
  - table = 16'h8000, mismatch_cnt = 0, pass = 1.
  - A..D step 0000→1111, 2 cycles per vector.
- Failing function: f tied 0, EXPECTED = 16'h8000.
  - table = 16'h0000, mismatch_cnt = 1, pass = 0.
  - Then f tied 1: table = 16'hFFFF, mismatch_cnt = 15, pass = 0.
- Parity with HOLD = 1: f = A^B^C^D, EXPECTED = 16'h6996.
  - table = 16'h6996, pass = 1, done 16 cycles after start.
  - busy high for exactly 16 cycles.
- Start while busy: extra start pulses at vectors 3 and 15, and during the done cycle.
  - No restart and no change to timing.
  - Exactly one done pulse; results identical to the baseline.
- Reset mid-sweep: assert rst asynchronously (between edges) while idx = 5.
  - All outputs 0 immediately; no done pulse.
  - A fresh start then completes normally with the baseline values.
- Back-to-back sweeps: a second start the cycle after DONE→IDLE.
  - table, mismatch_cnt and pass clear at accept, then reflect only the second sweep.
